// File: rtl/io_interrupt_controller.sv
// Memory-mapped interrupt controller: edge-detected pending bits, per-source enable,
// fixed priority (bit 0 highest), and a claim/complete handshake with no nesting.
module io_interrupt_controller #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] irq_src,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_write_data,
  input  logic        io_write_en,
  output logic [31:0] io_read_data,
  output logic        io_interrupt,
  output logic [4:0]  io_interrupt_id
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam logic [1:0] IDX_PENDING = 2'd0;
  localparam logic [1:0] IDX_ENABLE  = 2'd1;
  localparam logic [1:0] IDX_CLAIM   = 2'd2;
  localparam logic [1:0] IDX_STATUS  = 2'd3;

  state_t      state_q, state_d;
  logic [31:0] src_q;
  logic [31:0] pending_q, pending_d;
  logic [31:0] enable_q, enable_d;
  logic [4:0]  active_id_q, active_id_d;
  logic        in_service_q, in_service_d;
  logic        irq_q, irq_d;
  logic [4:0]  irq_id_q, irq_id_d;

  logic        sel;
  logic [1:0]  idx;
  logic        wr;
  logic [31:0] rise;
  logic [31:0] eligible;
  logic [4:0]  sel_id;
  logic        unused_ok;

  assign sel       = (io_addr[31:4] == BASE_ADDR[31:4]);
  assign idx       = io_addr[3:2];
  assign wr        = sel & io_write_en;
  assign rise      = irq_src & ~src_q;
  assign eligible  = pending_q & enable_q;
  assign unused_ok = ^io_addr[1:0];

  // Scan from the top so the lowest set index is the one that sticks.
  always_comb begin
    sel_id = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (eligible[i]) sel_id = 5'(i);
    end
  end

  always_comb begin
    io_read_data = 32'h0;
    if (sel) begin
      case (idx)
        IDX_PENDING: io_read_data = pending_q;
        IDX_ENABLE:  io_read_data = enable_q;
        IDX_CLAIM:   io_read_data = 32'h0;
        IDX_STATUS:  io_read_data = {23'd0, in_service_q, 3'd0, active_id_q};
        default:     io_read_data = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    enable_d     = enable_q;
    active_id_d  = active_id_q;
    in_service_d = in_service_q;
    irq_d        = irq_q;
    irq_id_d     = irq_id_q;

    if (wr && idx == IDX_PENDING) pending_d = pending_q & ~io_write_data;
    if (wr && idx == IDX_ENABLE)  enable_d  = io_write_data;

    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d  = REQ;
          irq_d    = 1'b1;
          irq_id_d = sel_id;
        end
      end
      REQ: begin
        if (wr && idx == IDX_CLAIM && io_write_data[4:0] == irq_id_q) begin
          pending_d[irq_id_q] = 1'b0;
          active_id_d  = irq_id_q;
          in_service_d = 1'b1;
          state_d      = SERVICE;
          irq_d        = 1'b0;
          irq_id_d     = 5'd0;
        end else if (eligible == 32'h0) begin
          state_d  = IDLE;
          irq_d    = 1'b0;
          irq_id_d = 5'd0;
        end else begin
          irq_id_d = sel_id;
        end
      end
      SERVICE: begin
        if (wr && idx == IDX_STATUS && io_write_data[4:0] == active_id_q) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        irq_d    = 1'b0;
        irq_id_d = 5'd0;
      end
    endcase

    // A fresh edge beats any clear (W1C or claim) of the same bit this cycle.
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      src_q        <= 32'h0;
      pending_q    <= 32'h0;
      enable_q     <= 32'h0;
      active_id_q  <= 5'd0;
      in_service_q <= 1'b0;
      irq_q        <= 1'b0;
      irq_id_q     <= 5'd0;
    end else begin
      state_q      <= state_d;
      src_q        <= irq_src;
      pending_q    <= pending_d;
      enable_q     <= enable_d;
      active_id_q  <= active_id_d;
      in_service_q <= in_service_d;
      irq_q        <= irq_d;
      irq_id_q     <= irq_id_d;
    end
  end

  assign io_interrupt    = irq_q;
  assign io_interrupt_id = irq_id_q;

endmodule

// File: tb/tb_io_interrupt_controller.sv
// Directed scenarios plus a randomized run, all checked against a cycle-level
// behavioural model of the controller's register and handshake rules.
module tb_io_interrupt_controller;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] irq_src;
  logic [31:0] io_addr;
  logic [31:0] io_write_data;
  logic        io_write_en;
  logic [31:0] io_read_data;
  logic        io_interrupt;
  logic [4:0]  io_interrupt_id;

  int checks = 0;
  int errors = 0;

  io_interrupt_controller #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .io_addr(io_addr),
    .io_write_data(io_write_data), .io_write_en(io_write_en),
    .io_read_data(io_read_data), .io_interrupt(io_interrupt),
    .io_interrupt_id(io_interrupt_id)
  );

  always #5 clk = ~clk;

  // Model: mode 0 = waiting, 1 = requesting, 2 = source being serviced.
  logic [31:0] m_pend, m_en, m_src;
  int          m_mode;
  int          m_id, m_active;

  function automatic int lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'h0;
    case (a[3:2])
      2'd0: return m_pend;
      2'd1: return m_en;
      2'd3: return ((m_mode == 2) ? 32'h100 : 32'h0) | 32'(m_active);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] elig, np;
    bit hit;
    int reg_i, wd;
    if (reset) begin
      m_pend = 0; m_en = 0; m_src = 0; m_mode = 0; m_id = 0; m_active = 0;
      return;
    end
    hit   = io_write_en && (io_addr[31:4] == BASE[31:4]);
    reg_i = int'(io_addr[3:2]);
    wd    = int'(io_write_data[4:0]);
    elig  = m_pend & m_en;
    np    = m_pend;
    if (hit && reg_i == 0) np = np & ~io_write_data;
    if (hit && reg_i == 1) m_en = io_write_data;
    if (m_mode == 0) begin
      if (elig != 0) begin m_mode = 1; m_id = lowest(elig); end
    end else if (m_mode == 1) begin
      if (hit && reg_i == 2 && wd == m_id) begin
        np[m_id] = 1'b0; m_active = m_id; m_mode = 2; m_id = 0;
      end else if (elig == 0) begin
        m_mode = 0; m_id = 0;
      end else begin
        m_id = lowest(elig);
      end
    end else begin
      if (hit && reg_i == 3 && wd == m_active) m_mode = 0;
    end
    m_pend = np | (irq_src & ~m_src);
    m_src  = irq_src;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("irq", 32'(io_interrupt), (m_mode == 1) ? 32'h1 : 32'h0);
    chk("irq_id", 32'(io_interrupt_id), 32'(m_id));
    chk("rdata", io_read_data, m_read(io_addr));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_addr = a; io_write_data = d; io_write_en = 1'b1;
    tick();
    io_write_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    io_addr = a;
    #1;
    chk(tag, io_read_data, exp);
  endtask

  task automatic chk_irq(input string tag, input logic v, input logic [4:0] id);
    chk({tag, "_irq"}, 32'(io_interrupt), 32'(v));
    chk({tag, "_id"}, 32'(io_interrupt_id), 32'(id));
  endtask

  initial begin
    int r;
    reset = 1'b1; irq_src = 0; io_addr = 0; io_write_data = 0; io_write_en = 0;
    tick(); tick();
    reset = 1'b0;
    chk_irq("reset", 1'b0, 5'd0);
    rd("reset_pend", BASE + 32'h0, 32'h0);
    rd("reset_en", BASE + 32'h4, 32'h0);
    rd("reset_stat", BASE + 32'hC, 32'h0);

    // Single source edge to request
    wr(BASE + 32'h4, 32'h8);
    io_addr = BASE; irq_src = 32'h8;
    tick();
    rd("edge_pend", BASE, 32'h8);
    chk_irq("edge_noirq", 1'b0, 5'd0);
    irq_src = 0;
    tick();
    chk_irq("edge_req", 1'b1, 5'd3);

    // Mismatched claim, then disable
    wr(BASE + 32'h8, 32'd4);
    chk_irq("badclaim", 1'b1, 5'd3);
    wr(BASE + 32'h4, 32'h0);
    tick();
    chk_irq("disable", 1'b0, 5'd0);
    rd("disable_pend", BASE, 32'h8);
    wr(BASE, 32'hFFFF_FFFF);
    rd("w1c", BASE, 32'h0);

    // Priority, claim, complete
    wr(BASE + 32'h4, 32'hFFFF_FFFF);
    irq_src = 32'h220;
    tick();
    irq_src = 0;
    tick();
    chk_irq("prio", 1'b1, 5'd5);
    wr(BASE + 32'h8, 32'd5);
    chk_irq("claim5", 1'b0, 5'd0);
    rd("claim5_stat", BASE + 32'hC, 32'h105);
    rd("claim5_pend", BASE, 32'h200);
    wr(BASE + 32'hC, 32'd5);
    chk_irq("complete5", 1'b0, 5'd0);
    tick();
    chk_irq("next9", 1'b1, 5'd9);

    // Set beats W1C during service; no nesting
    wr(BASE + 32'h8, 32'd9);
    rd("claim9_stat", BASE + 32'hC, 32'h109);
    irq_src = 32'h1;
    wr(BASE, 32'h1);
    irq_src = 0;
    rd("setwins", BASE, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_irq("nonest", 1'b0, 5'd0);
    end
    wr(BASE + 32'hC, 32'd3);
    chk_irq("badcomplete", 1'b0, 5'd0);
    rd("badcomplete_stat", BASE + 32'hC, 32'h109);
    wr(BASE + 32'hC, 32'd9);
    tick();
    chk_irq("after9", 1'b1, 5'd0);

    // Reset during service overrides a write; held source gives one edge
    wr(BASE + 32'h8, 32'd0);
    rd("claim0_stat", BASE + 32'hC, 32'h100);
    irq_src = 32'h80; reset = 1'b1;
    wr(BASE + 32'h4, 32'hFFFF);
    reset = 1'b0;
    rd("rst_stat", BASE + 32'hC, 32'h0);
    rd("rst_pend", BASE, 32'h0);
    rd("rst_en", BASE + 32'h4, 32'h0);
    chk_irq("rst", 1'b0, 5'd0);
    io_addr = BASE;
    tick();
    rd("held_pend", BASE, 32'h80);
    wr(BASE, 32'h80);
    tick();
    rd("held_once", BASE, 32'h0);
    irq_src = 0;

    // Address decode
    wr(BASE + 32'h6, 32'h1234);
    rd("lowbits", BASE + 32'h4, 32'h1234);
    rd("oow_rd", BASE + 32'h10, 32'h0);
    wr(BASE + 32'h10, 32'hFFFF_FFFF);
    rd("oow_wr", BASE + 32'h4, 32'h1234);
    wr(BASE - 32'h4, 32'hFFFF_FFFF);
    rd("oow_below", BASE + 32'h4, 32'h1234);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) irq_src = irq_src ^ (32'h1 << $urandom_range(0, 31));
      r = $urandom_range(0, 15);
      io_write_en = 1'b1;
      case (r)
        0: begin io_addr = BASE + 32'h4; io_write_data = $urandom & $urandom; end
        1: begin io_addr = BASE; io_write_data = $urandom & $urandom & $urandom; end
        2: begin io_addr = BASE + 32'h8; io_write_data = $urandom; end
        3, 4: begin io_addr = BASE + 32'h8; io_write_data = 32'(m_id); end
        5: begin io_addr = BASE + 32'hC; io_write_data = 32'(m_active); end
        6: begin io_addr = BASE + 32'hC; io_write_data = $urandom; end
        7: begin io_addr = BASE + 32'h10 + 32'($urandom_range(0, 15)); io_write_data = $urandom; end
        default: begin
          io_write_en = 1'b0;
          io_addr = BASE + 32'($urandom_range(0, 15));
        end
      endcase
      reset = ($urandom_range(0, 399) == 0);
      tick();
      reset = 1'b0; io_write_en = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
